// File: rtl/pocket_gamepad_pkg.sv
// pocket_gamepad_pkg: shared pad layout constants and slice helper for the gamepad conditioner
package pocket_gamepad_pkg;
    localparam int PAD_W  = 16;
    localparam int PAD_U  = 0;
    localparam int PAD_D  = 1;
    localparam int PAD_L  = 2;
    localparam int PAD_R  = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_X  = 6;
    localparam int BTN_Y  = 7;
    localparam int BTN_L1 = 8;
    localparam int BTN_R1 = 9;
    localparam int BTN_L2 = 10;
    localparam int BTN_R2 = 11;
    localparam int BTN_L3 = 12;
    localparam int BTN_R3 = 13;
    localparam int BTN_SE = 14;
    localparam int BTN_ST = 15;

    function automatic int pad_slice(input int p);
        return p * PAD_W;
    endfunction
endpackage

// File: rtl/pocket_gamepad_debounce.sv
// pocket_gamepad_debounce: one-bit synchroniser, debouncer and registered edge detector
// iCLK/iRST: core clock, async active-high reset; raw: async input bit
// db: debounced state; press/rel: one-cycle pulses on db rising/falling
module pocket_gamepad_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic raw,
    output logic db,
    output logic press,
    output logic rel
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic db_q;
    logic s;
    assign s = sync[SYNC_STAGES-1];
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sync  <= '0;
            cnt   <= '0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            db_q  <= db;
            press <= db & ~db_q;
            rel   <= ~db & db_q;
            if (s == db)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= s;
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/pocket_gamepad_multi.sv
// pocket_gamepad_multi: multi-pad input conditioner (sync, debounce, SOCD, edge pulses, turbo)
// iCLK/iRST: core clock, async active-high reset; iJOY: raw pad words, pad p at [16p+15:16p]
// iTURBO_EN/iTURBO_MASK: autofire enable and per-button mask; oKEYS: conditioned keys
// oPRESS/oRELEASE: one-cycle pulses on debounced press/release (pre-SOCD, pre-turbo)
module pocket_gamepad_multi
    import pocket_gamepad_pkg::*;
#(
    parameter int NUM_PADS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURBO_HALF      = 3
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [PAD_W*NUM_PADS-1:0] iJOY,
    input  logic                      iTURBO_EN,
    input  logic [PAD_W-1:0]          iTURBO_MASK,
    output logic [PAD_W*NUM_PADS-1:0] oKEYS,
    output logic [PAD_W*NUM_PADS-1:0] oPRESS,
    output logic [PAD_W*NUM_PADS-1:0] oRELEASE
);
    localparam int W  = PAD_W * NUM_PADS;
    localparam int TW = TURBO_HALF > 1 ? $clog2(TURBO_HALF) : 1;
    logic [W-1:0] db;
    logic [W-1:0] clean;
    logic [TW-1:0] tcnt;
    logic phase;
    logic [PAD_W-1:0] gate;
    genvar i, p;
    for (i = 0; i < W; i++) begin : g_bit
        pocket_gamepad_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .iCLK(iCLK),
            .iRST(iRST),
            .raw(iJOY[i]),
            .db(db[i]),
            .press(oPRESS[i]),
            .rel(oRELEASE[i])
        );
    end
    // opposing D-pad directions cancel to neutral
    for (p = 0; p < NUM_PADS; p++) begin : g_pad
        localparam int B = pad_slice(p);
        logic [PAD_W-1:0] d;
        logic ud, lr;
        assign d  = db[B +: PAD_W];
        assign ud = d[PAD_U] & d[PAD_D];
        assign lr = d[PAD_L] & d[PAD_R];
        assign clean[B +: PAD_W] = d & ~(PAD_W'({lr, lr, ud, ud}));
    end
    // masked buttons are forced low during the off half of the turbo phase
    assign gate = (iTURBO_EN & ~phase) ? iTURBO_MASK : '0;
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            tcnt  <= '0;
            phase <= 1'b1;
            oKEYS <= '0;
        end else begin
            oKEYS <= clean & ~{NUM_PADS{gate}};
            if (!iTURBO_EN) begin
                tcnt  <= '0;
                phase <= 1'b1;
            end else if (tcnt == TW'(TURBO_HALF - 1)) begin
                tcnt  <= '0;
                phase <= ~phase;
            end else
                tcnt <= tcnt + TW'(1);
        end
    end
endmodule

// File: tb/tb_pocket_gamepad_multi.sv
// tb_pocket_gamepad_multi: directed self-checking bench for pocket_gamepad_multi
module tb_pocket_gamepad_multi;
    logic        clk;
    logic        rst;
    logic [31:0] joy;
    logic        ten;
    logic [15:0] tmask;
    logic [31:0] keys, press, rel;
    int vectors = 0;
    int miscompares = 0;

    pocket_gamepad_multi #(
        .NUM_PADS(2),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .TURBO_HALF(3)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .iJOY(joy),
        .iTURBO_EN(ten),
        .iTURBO_MASK(tmask),
        .oKEYS(keys),
        .oPRESS(press),
        .oRELEASE(rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; joy = '0; ten = 1'b0; tmask = '0;
        // reset / idle
        tick(3);
        chk("rst_keys", keys, 32'h0);
        chk("rst_press", press, 32'h0);
        chk("rst_rel", rel, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("idle_keys", keys, 32'h0);
            chk("idle_press", press, 32'h0);
            chk("idle_rel", rel, 32'h0);
        end
        // clean press on pad 0 A
        joy = 32'h0000_0010;
        tick(6);
        chk("press_early_keys", keys, 32'h0);
        chk("press_early_pulse", press, 32'h0);
        tick(1);
        chk("press_keys", keys, 32'h0000_0010);
        chk("press_pulse", press, 32'h0000_0010);
        tick(1);
        chk("press_pulse_end", press, 32'h0);
        chk("press_keys_hold", keys, 32'h0000_0010);
        joy = 32'h0;
        tick(6);
        chk("rel_early_keys", keys, 32'h0000_0010);
        chk("rel_early_pulse", rel, 32'h0);
        tick(1);
        chk("rel_keys", keys, 32'h0);
        chk("rel_pulse", rel, 32'h0000_0010);
        tick(1);
        chk("rel_pulse_end", rel, 32'h0);
        // 3-cycle glitch on pad 1 A is rejected
        joy = 32'h0010_0000;
        tick(3);
        joy = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("glitch_keys", keys, 32'h0);
            chk("glitch_press", press, 32'h0);
        end
        // 4-cycle pulse is accepted
        joy = 32'h0010_0000;
        tick(4);
        joy = 32'h0;
        tick(3);
        chk("pulse4_keys", keys, 32'h0010_0000);
        chk("pulse4_press", press, 32'h0010_0000);
        tick(4);
        chk("pulse4_rel_keys", keys, 32'h0);
        chk("pulse4_rel", rel, 32'h0010_0000);
        tick(2);
        // SOCD: U+D cancel, L passes
        joy = 32'h0000_0007;
        tick(7);
        chk("socd_keys", keys, 32'h0000_0004);
        chk("socd_press", press, 32'h0000_0007);
        tick(1);
        chk("socd_press_end", press, 32'h0);
        chk("socd_keys_hold", keys, 32'h0000_0004);
        joy = 32'h0;
        tick(10);
        chk("socd_clear", keys, 32'h0);
        // turbo on A, B held steady
        tmask = 16'h0010; ten = 1'b1; joy = 32'h0000_0030;
        tick(7);
        chk("turbo_first", keys, 32'h0000_0030);
        chk("turbo_press", press, 32'h0000_0030);
        for (int k = 7; k < 19; k++) begin
            tick(1);
            chk("turbo_keys", keys, ((k / 3) % 2 == 0) ? 32'h0000_0030 : 32'h0000_0020);
            chk("turbo_no_press", press, 32'h0);
        end
        ten = 1'b0; tmask = '0;
        tick(1);
        chk("turbo_off", keys, 32'h0000_0030);
        joy = 32'h0;
        tick(12);
        chk("turbo_clear", keys, 32'h0);
        // async reset mid-count
        joy = 32'h0000_0200;
        tick(8);
        chk("pre_rst_keys", keys, 32'h0000_0200);
        joy = 32'h0000_0280;
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk("async_keys", keys, 32'h0);
        chk("async_press", press, 32'h0);
        chk("async_rel", rel, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("post_rst_early_keys", keys, 32'h0);
        chk("post_rst_early_press", press, 32'h0);
        tick(1);
        chk("post_rst_keys", keys, 32'h0000_0280);
        chk("post_rst_press", press, 32'h0000_0280);
        tick(1);
        chk("post_rst_press_end", press, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
